// File: rtl/fpu_issue_stage.sv
// ============================================================================
// Module   : fpu_issue_stage
// Brief    : Operand queue plus one-in-flight issue controller for an FPU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_issue_stage #(
    parameter int DEPTH   = 4,
    parameter int FPU_LAT = 5,
    parameter int TAG_W   = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_a,
    input  logic [31:0]                in_b,
    input  logic [1:0]                 in_sel,
    input  logic [TAG_W-1:0]           in_tag,
    output logic [31:0]                fpu_a,
    output logic [31:0]                fpu_b,
    output logic [1:0]                 fpu_sel,
    input  logic [31:0]                fpu_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_data,
    output logic [TAG_W-1:0]           out_tag,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_LW = $clog2(FPU_LAT + 1);
    localparam int c_EW = 32 + 32 + 2 + TAG_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_EW-1:0]    r_mem [DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_CW-1:0]    r_count;
    logic [c_LW-1:0]    r_lat;
    logic [TAG_W-1:0]   r_tag_inflight;
    logic [31:0]        r_fpu_a;
    logic [31:0]        r_fpu_b;
    logic [1:0]         r_fpu_sel;
    logic               r_out_valid;
    logic [31:0]        r_out_data;
    logic [TAG_W-1:0]   r_out_tag;

    logic               w_push;
    logic               w_issue;
    logic [c_EW-1:0]    w_head;

    assign in_ready = (r_count < c_CW'(DEPTH));
    assign w_push   = in_valid && in_ready;
    // An issue either starts from idle or chains directly off a result accept.
    assign w_issue  = (r_count != '0) &&
                      ((r_state == S_IDLE) || ((r_state == S_RESULT) && out_ready));
    assign w_head   = r_mem[r_rd_ptr];

    assign fpu_a     = r_fpu_a;
    assign fpu_b     = r_fpu_b;
    assign fpu_sel   = r_fpu_sel;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_tag   = r_out_tag;
    assign count     = r_count;

    // Storage array carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_a, in_b, in_sel, in_tag};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_lat          <= '0;
            r_tag_inflight <= '0;
            r_fpu_a        <= '0;
            r_fpu_b        <= '0;
            r_fpu_sel      <= '0;
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
            r_out_tag      <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_count <= r_count + c_CW'(w_push) - c_CW'(w_issue);

            if (w_issue) begin
                r_rd_ptr       <= r_rd_ptr + 1'b1;
                {r_fpu_a, r_fpu_b, r_fpu_sel, r_tag_inflight} <= w_head;
                r_lat          <= c_LW'(FPU_LAT);
            end

            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Sample on the edge that takes the counter to zero.
                    if (r_lat <= c_LW'(1)) begin
                        r_lat       <= '0;
                        r_out_data  <= fpu_out;
                        r_out_tag   <= r_tag_inflight;
                        r_out_valid <= 1'b1;
                        r_state     <= S_RESULT;
                    end else begin
                        r_lat <= r_lat - 1'b1;
                    end
                end
                S_RESULT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= w_issue ? S_WAIT : S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fpu_issue_stage.sv
// ============================================================================
// Module   : tb_fpu_issue_stage
// Brief    : Directed, table-driven self-checking bench for fpu_issue_stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpu_issue_stage;

    localparam int DEPTH   = 4;
    localparam int FPU_LAT = 5;
    localparam int TAG_W   = 5;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_a = '0;
    logic [31:0]      in_b = '0;
    logic [1:0]       in_sel = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic [31:0]      fpu_a;
    logic [31:0]      fpu_b;
    logic [1:0]       fpu_sel;
    logic [31:0]      fpu_out;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic [CW-1:0]    count;

    int n_vec = 0;
    int n_err = 0;

    fpu_issue_stage #(.DEPTH(DEPTH), .FPU_LAT(FPU_LAT), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_tag(in_tag),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_sel(fpu_sel), .fpu_out(fpu_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .count(count)
    );

    always #5 clk = ~clk;

    // Stand-in FPU: exact IEEE results for equal-operand add/sub, positive-only
    // compare, and an arbitrary bit mix for mul (the stage never looks inside).
    function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] sel);
        case (sel)
            2'd0:    return (a == b) ? a + 32'h0080_0000 : a ^ b;
            2'd1:    return (a == b) ? 32'h0 : a - b;
            2'd2:    return a ^ {b[15:0], b[31:16]};
            default: return (a < b) ? 32'h1 : 32'h0;
        endcase
    endfunction

    // Output is garbage until the operands have been stable long enough.
    logic [65:0] prev_bus = '0;
    int          age = 15;
    always @(posedge clk) begin
        if ({fpu_a, fpu_b, fpu_sel} != prev_bus) age <= 0;
        else if (age < 15) age <= age + 1;
        prev_bus <= {fpu_a, fpu_b, fpu_sel};
    end
    assign fpu_out = (age >= FPU_LAT - 2) ? fpu_model(fpu_a, fpu_b, fpu_sel) : 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [1:0]       sel;
        logic [TAG_W-1:0] tag;
        logic [31:0]      exp;
    } vec_t;

    vec_t tbl [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_op(input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] sel, input logic [TAG_W-1:0] tag);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1; in_a = a; in_b = b; in_sel = sel; in_tag = tag;
        for (int i = 0; i < 200 && !ok; i++) begin
            ok = in_ready;
            step();
        end
        in_valid = 1'b0;
        if (!ok) chk("push_timeout", 32'(ok), 32'h1);
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 100 && !out_valid; i++) step();
        if (!out_valid) chk(name, 32'(out_valid), 32'h1);
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_out_valid"}, 32'(out_valid), 32'h0);
        chk({name, "_count"},     32'(count),     32'h0);
        chk({name, "_in_ready"},  32'(in_ready),  32'h1);
        chk({name, "_fpu_a"},     fpu_a,          32'h0);
        chk({name, "_fpu_b"},     fpu_b,          32'h0);
        chk({name, "_fpu_sel"},   32'(fpu_sel),   32'h0);
    endtask

    initial begin
        tbl[0] = '{32'h41B8_0000, 32'h41B8_0000, 2'd0, 5'd3,  32'h4238_0000};
        tbl[1] = '{32'h3F80_0000, 32'h3F80_0000, 2'd0, 5'd9,  32'h4000_0000};
        tbl[2] = '{32'h4049_0FDB, 32'h4049_0FDB, 2'd1, 5'd7,  32'h0000_0000};
        tbl[3] = '{32'h1234_5678, 32'h9ABC_DEF0, 2'd2, 5'd31, 32'hCCC4_CCC4};
        tbl[4] = '{32'h41B8_0000, 32'h41B8_0001, 2'd3, 5'd0,  32'h0000_0001};
        tbl[5] = '{32'hC000_0000, 32'h3F80_0000, 2'd3, 5'd17, 32'h0000_0000};
        tbl[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0, 5'd1,  32'h007F_FFFF};
        tbl[7] = '{32'h0000_0000, 32'h0000_FFFF, 2'd2, 5'd2,  32'hFFFF_0000};

        #1;
        chk_reset_vals("rst_init");
        repeat (2) step();
        rst = 1'b0;

        // Single ops into an idle stage: exact latency and data/tag delivery.
        for (int i = 0; i < 8; i++) begin
            out_ready = 1'b0;
            push_op(tbl[i].a, tbl[i].b, tbl[i].sel, tbl[i].tag);
            chk($sformatf("v%0d_count_q", i), 32'(count), 32'h1);
            step();
            chk($sformatf("v%0d_fpu_a", i), fpu_a, tbl[i].a);
            chk($sformatf("v%0d_fpu_b", i), fpu_b, tbl[i].b);
            chk($sformatf("v%0d_fpu_sel", i), 32'(fpu_sel), 32'(tbl[i].sel));
            repeat (FPU_LAT - 1) step();
            chk($sformatf("v%0d_early", i), 32'(out_valid), 32'h0);
            step();
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'h1);
            chk($sformatf("v%0d_data", i), out_data, tbl[i].exp);
            chk($sformatf("v%0d_tag", i), 32'(out_tag), 32'(tbl[i].tag));
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            chk($sformatf("v%0d_clear", i), 32'(out_valid), 32'h0);
        end

        // Fill: one issued plus DEPTH queued, then drain in order.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_op(32'h3F80_0000, 32'h3F80_0000, 2'd0, TAG_W'(i));
        chk("fill_count", 32'(count), 32'h4);
        chk("fill_ready", 32'(in_ready), 32'h0);
        out_ready = 1'b1;
        fork
            push_op(32'h3F80_0000, 32'h3F80_0000, 2'd0, TAG_W'(5));
            begin
                int exp_tag;
                exp_tag = 0;
                for (int c = 0; c < 400 && exp_tag < 6; c++) begin
                    if (out_valid) begin
                        chk($sformatf("fill_tag%0d", exp_tag), 32'(out_tag), 32'(exp_tag));
                        chk($sformatf("fill_data%0d", exp_tag), out_data, 32'h4000_0000);
                        exp_tag++;
                    end
                    step();
                end
                if (exp_tag != 6) chk("fill_drain", 32'(exp_tag), 32'd6);
            end
        join
        out_ready = 1'b0;
        chk("fill_empty", 32'(count), 32'h0);

        // Backpressure: result held with a queued op behind it.
        push_op(tbl[3].a, tbl[3].b, tbl[3].sel, tbl[3].tag);
        wait_valid("bp_wait");
        push_op(tbl[1].a, tbl[1].b, tbl[1].sel, tbl[1].tag);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 32'(out_valid), 32'h1);
            chk("bp_data", out_data, tbl[3].exp);
            chk("bp_tag", 32'(out_tag), 32'(tbl[3].tag));
            chk("bp_fpu_a", fpu_a, tbl[3].a);
            chk("bp_count", 32'(count), 32'h1);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_next_issue", fpu_a, tbl[1].a);
        wait_valid("bp_wait2");
        chk("bp_data2", out_data, tbl[1].exp);
        chk("bp_tag2", 32'(out_tag), 32'(tbl[1].tag));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset mid-WAIT with two queued ops: everything discarded.
        push_op(tbl[0].a, tbl[0].b, tbl[0].sel, 5'd11);
        push_op(tbl[1].a, tbl[1].b, tbl[1].sel, 5'd12);
        push_op(tbl[2].a, tbl[2].b, tbl[2].sel, 5'd13);
        chk("mid_count", 32'(count), 32'h2);
        rst = 1'b1;
        #1;
        chk_reset_vals("rst_mid");
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("post_rst_valid", 32'(out_valid), 32'h0);
            step();
        end
        chk("post_rst_count", 32'(count), 32'h0);

        // Back-to-back cmp then sub: second issue on the first accept edge.
        push_op(32'h41B8_0000, 32'h41B8_0001, 2'd3, 5'd20);
        push_op(32'h41B8_0000, 32'h41B8_0000, 2'd1, 5'd21);
        wait_valid("b2b_wait");
        chk("b2b_data1", out_data, 32'h0000_0001);
        chk("b2b_tag1", 32'(out_tag), 32'd20);
        step();
        chk("b2b_clear", 32'(out_valid), 32'h0);
        chk("b2b_issue_sel", 32'(fpu_sel), 32'h1);
        chk("b2b_issue_b", fpu_b, 32'h41B8_0000);
        repeat (FPU_LAT - 1) step();
        chk("b2b_early", 32'(out_valid), 32'h0);
        step();
        chk("b2b_valid2", 32'(out_valid), 32'h1);
        chk("b2b_data2", out_data, 32'h0000_0000);
        chk("b2b_tag2", 32'(out_tag), 32'd21);
        step();
        chk("b2b_done", 32'(out_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/fpu_issue_stage.md
FPU_ISSUE_STAGE -- requirements
Module: fpu_issue_stage

Interface
REQ-001 SHALL have parameter DEPTH, 4, operand-queue entries (power of two, >=2).
REQ-002 SHALL have parameter FPU_LAT, 5, clock edges from FPU input change to valid Out_0.
REQ-003 SHALL have parameter TAG_W, 5, destination-register tag width.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  upstream op valid.
REQ-007 SHALL have port in_ready  output  1  queue can accept an op.
REQ-008 SHALL have ports in_a, in_b  input  32 each  IEEE-754 single operands.
REQ-009 SHALL have port in_sel  input  2  op: 0 add, 1 sub, 2 mul, 3 cmp.
REQ-010 SHALL have port in_tag  input  TAG_W  destination tag.
REQ-011 SHALL have ports fpu_a, fpu_b  output  32 each  registered operands to FPU A/B.
REQ-012 SHALL have port fpu_sel  output  2  registered op to FPU Sel.
REQ-013 SHALL have port fpu_out  input  32  FPU Out_0.
REQ-014 SHALL have port out_valid  output  1  result valid.
REQ-015 SHALL have port out_ready  input  1  downstream accepts result.
REQ-016 SHALL have ports out_data  output  32, out_tag  output  TAG_W  result and its tag.
REQ-017 SHALL have port count  output  clog2(DEPTH)+1  queued (not issued) entries.

Function
REQ-018 SHALL push {in_a,in_b,in_sel,in_tag} into a FIFO on an edge with in_valid && in_ready; in_ready = (count < DEPTH), no same-cycle full bypass.
REQ-019 SHALL implement states IDLE, WAIT, RESULT; exactly one op in flight at any time.
REQ-020 IDLE: if count>0, pop head, load fpu_a/fpu_b/fpu_sel, load latency counter with FPU_LAT, go WAIT on the same edge; else stay.
REQ-021 WAIT: decrement counter each edge; on the edge where counter reaches 0, sample fpu_out into out_data, the in-flight tag into out_tag, set out_valid, go RESULT.
REQ-022 fpu_a/fpu_b/fpu_sel SHALL change only on an issue edge and hold their last values otherwise.
REQ-023 RESULT: out_valid, out_data, out_tag SHALL stay stable until out_valid && out_ready.
REQ-024 On result accept edge: clear out_valid; if count>0, issue next head on the same edge (go WAIT), else go IDLE.
REQ-025 Latency: op accepted at edge T into an empty, idle stage SHALL produce out_valid high after edge T+1+FPU_LAT.
REQ-026 Results SHALL leave in acceptance order; tags never reordered or duplicated.
REQ-027 Push and pop on the same edge SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-028 Block SHALL not inspect or alter operand/result bit patterns (pass-through of FP values).

Reset
REQ-029 While rst=1: state IDLE, count 0, FIFO pointers 0, latency counter 0, out_valid 0, out_data 0, out_tag 0, fpu_a 0, fpu_b 0, fpu_sel 0; in_ready SHALL be 1.
REQ-030 Reset asserted mid-operation SHALL discard queued and in-flight ops; no out_valid SHALL follow for them after release.

Verification
REQ-031 Reset: rst pulse at any state -> out_valid=0, count=0, in_ready=1, fpu_a=fpu_b=0, fpu_sel=0 immediately.
REQ-032 Single add: in_a=in_b=0x41B80000, sel=0, tag=3, FPU model (FPU_LAT=5) returns 0x42380000 -> out_valid high 6 edges after accept, out_data=0x42380000, out_tag=3.
REQ-033 Fill: out_ready=0, 6 back-to-back pushes, tags 0..5 -> 5 accepted (1 issued + 4 queued), in_ready=0 at 6th, count=4; then out_ready=1 -> tags 0..4 emerge in order, 6th accepted once in_ready rises.
REQ-034 Backpressure: out_ready held 0 for 10 cycles in RESULT -> out_data/out_tag stable, fpu_* unchanged, no new issue.
REQ-035 Reset mid-WAIT with 2 queued ops -> after release out_valid stays 0 for 20 cycles, count=0.
REQ-036 Back-to-back cmp (sel=3, A=0x41B80000, B=0x41B80001) then sub (sel=1, equal operands) with out_ready=1 -> second issue on first accept edge, results equal FPU model outputs with tags in order.
